// File: rtl/bcd_scan_display_pkg.sv
// rtl/bcd_scan_display_pkg.sv - shared types, segment table and BCD constants for the scan display
package bcd_scan_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  localparam logic [3:0] BCD_THRESHOLD = 4'd5;
  localparam logic [3:0] BCD_ADD       = 4'd3;

  // Active-high segments, bit6 = a ... bit0 = g; hex letters use b/d lower-case shapes.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    return SEG_LUT[nibble];
  endfunction

  function automatic int dec_digits_needed(input int bin_width);
    longint unsigned v;
    int n;
    v = (64'd1 << bin_width) - 64'd1;
    n = 0;
    do begin
      n++;
      v = v / 64'd10;
    end while (v != 64'd0);
    return n;
  endfunction

endpackage

// File: rtl/bcd_scan_display_if.sv
// rtl/bcd_scan_display_if.sv - load/display signal bundle between pad logic and the scan display
interface bcd_scan_display_if #(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 3
);
  localparam int PLACE_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [BIN_WIDTH-1:0] binary;
  logic                 load;
  logic                 hex_mode;
  logic                 busy;
  logic [3:0]           digit;
  logic [PLACE_W-1:0]   digit_place;
  logic                 frame_start;
  logic                 blank;
  logic [6:0]           abcdefg;

  modport master (
    output binary, load, hex_mode,
    input  busy, digit, digit_place, frame_start, blank, abcdefg
  );

  modport slave (
    input  binary, load, hex_mode,
    output busy, digit, digit_place, frame_start, blank, abcdefg
  );
endinterface

// File: rtl/bcd_shift_add3.sv
// rtl/bcd_shift_add3.sv - one combinational correct-then-shift step of the double-dabble converter
module bcd_shift_add3
  import bcd_scan_display_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic [4*DIGITS-1:0] acc_in,
  input  logic                bit_in,
  input  logic                hex,
  output logic [4*DIGITS-1:0] acc_out
);

  logic [4*DIGITS-1:0] corrected;
  logic [3:0]          nib;

  always_comb begin
    corrected = acc_in;
    nib       = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = acc_in[i*4 +: 4];
      // Hex mode bypasses correction so the accumulator ends up holding raw nibbles.
      if (!hex && nib >= BCD_THRESHOLD) begin
        corrected[i*4 +: 4] = nib + BCD_ADD;
      end
    end
    acc_out = (corrected << 1) | {{(4*DIGITS-1){1'b0}}, bit_in};
  end

endmodule

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - serial binary-to-BCD/hex converter with double-buffered scanned 7-seg output
// Optional feature macro: LEADING_ZERO_BLANK_EN
module bcd_scan_display
  import bcd_scan_display_pkg::*;
#(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 3,
  parameter int SCAN_DIV  = 1024
) (
  input logic               clock,
  input logic               reset,
  bcd_scan_display_if.slave bus
);

  localparam int PLACE_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W   = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
  localparam int PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int ACC_W   = 4 * DIGITS;

  if (DIGITS < dec_digits_needed(BIN_WIDTH) || 4 * DIGITS < BIN_WIDTH) begin : g_bad_digits
    $error("bcd_scan_display: DIGITS too small for BIN_WIDTH");
  end
  if (SCAN_DIV < 1) begin : g_bad_scan_div
    $error("bcd_scan_display: SCAN_DIV must be at least 1");
  end

  state_t               state, state_nx;
  logic [BIN_WIDTH-1:0] shift_reg;
  logic [ACC_W-1:0]     acc, acc_step;
  logic [ACC_W-1:0]     display;
  logic                 hex_q;
  logic [CNT_W-1:0]     bit_cnt;
  logic [PRE_W-1:0]     prescale;
  logic [PLACE_W-1:0]   place;
  logic [3:0]           cur_digit;
  logic                 cur_blank;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.load) state_nx = SHIFT;
      SHIFT:   if (bit_cnt == CNT_W'(BIN_WIDTH - 1)) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  bcd_shift_add3 #(.DIGITS(DIGITS)) u_step (
    .acc_in  (acc),
    .bit_in  (shift_reg[BIN_WIDTH-1]),
    .hex     (hex_q),
    .acc_out (acc_step)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      acc       <= '0;
      display   <= '0;
      hex_q     <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            shift_reg <= bus.binary;
            hex_q     <= bus.hex_mode;
            acc       <= '0;
            bit_cnt   <= '0;
          end
        end
        SHIFT: begin
          acc       <= acc_step;
          shift_reg <= shift_reg << 1;
          bit_cnt   <= bit_cnt + 1'b1;
        end
        COMMIT: display <= acc;
        default: ;
      endcase
    end
  end

  // Scan timing is free-running and deliberately unaware of conversions.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescale <= '0;
      place    <= '0;
    end else if (prescale == PRE_W'(SCAN_DIV - 1)) begin
      prescale <= '0;
      place    <= (place == PLACE_W'(DIGITS - 1)) ? '0 : place + 1'b1;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  always_comb begin
    cur_digit = display[3:0];
    for (int i = 0; i < DIGITS; i++) begin
      if (place == PLACE_W'(i)) cur_digit = display[i*4 +: 4];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_above;

  // Walk from the top digit down so zero_above means "this and all higher digits are 0".
  always_comb begin
    zero_above = 1'b1;
    cur_blank  = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (display[i*4 +: 4] == 4'd0);
      if (i != 0 && place == PLACE_W'(i) && zero_above) cur_blank = 1'b1;
    end
  end
`else
  assign cur_blank = 1'b0;
`endif

  assign bus.busy        = (state != IDLE);
  assign bus.digit       = cur_digit;
  assign bus.digit_place = place;
  assign bus.frame_start = (place == '0);
  assign bus.blank       = cur_blank;
  assign bus.abcdefg     = cur_blank ? 7'b0 : seg_decode(cur_digit);

endmodule
